// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: in-order instruction prefetcher feeding the IF/ID register; flushes on redirect.
// Latency: grant + memory latency + 1 cycle to out_valid. The FIFO has no bypass path.
// Backpressure: stall holds the head; issue is credit-limited so that (count + live inflight) < DEPTH.
// Optional: define PREFETCH_PERF_EN to add the perf_empty_cycles / perf_discards counters.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_empty_cycles,
  output logic [31:0] perf_discards
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q,  discard_d;
  logic [CW-1:0] count_q,    count_d;
  logic [PW-1:0] tag_wr_q,   tag_wr_d;
  logic [PW-1:0] tag_rd_q,   tag_rd_d;
  logic [PW-1:0] fifo_wr_q,  fifo_wr_d;
  logic [PW-1:0] fifo_rd_q,  fifo_rd_d;

  logic [31:0] tag_mem   [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic          issue;
  logic          rsp;
  logic          fifo_push;
  logic          rsp_drop;
  logic          pop;
  logic [CW:0]   credit_used;

  // Slots already promised: buffered words plus live (non-discarded) requests in flight.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q - discard_q};

  assign imem_req  = !reset && !redirect && (credit_used < DEPTH_W) && (inflight_q < DEPTH_C);
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_gnt;

  // Responses with nothing outstanding are ignored.
  assign rsp       = imem_rvalid && (inflight_q != '0);
  assign fifo_push = rsp && (discard_q == '0) && !redirect;
  assign rsp_drop  = rsp && !fifo_push;

  assign out_valid = !reset && (count_q != '0) && !redirect;
  assign out_instr = reset ? 32'h0 : instr_mem[fifo_rd_q];
  assign out_pc    = reset ? 32'h0 : pc_mem[fifo_rd_q];
  assign pop       = out_valid && !stall;

  // Next-state for fetch PC, outstanding/discard accounting and both FIFO pointer sets.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;

    if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      tag_wr_d   = tag_wr_q + PW'(1);
    end

    inflight_d = inflight_q + CW'(issue) - CW'(rsp);

    if (rsp && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end

    if (fifo_push) begin
      fifo_wr_d = fifo_wr_q + PW'(1);
      tag_rd_d  = tag_rd_q + PW'(1);
    end

    if (pop) begin
      fifo_rd_d = fifo_rd_q + PW'(1);
    end

    count_d = count_q + CW'(fifo_push) - CW'(pop);

    // Redirect: everything still outstanding after this cycle becomes stale.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      discard_d  = inflight_d;
      count_d    = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
    end
  end

  // Storage: PC tag per issued request, and {instr, pc} per kept response.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[tag_wr_q] <= fetch_pc_q;
    end
    if (!reset && fifo_push) begin
      instr_mem[fifo_wr_q] <= imem_rdata;
      pc_mem[fifo_wr_q]    <= tag_mem[tag_rd_q];
    end
  end

  a_rsp_legal: assert property (@(posedge clk) disable iff (reset)
                                imem_rvalid |-> (inflight_q != '0));

`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_empty_q;
  logic [31:0] perf_disc_q;

  // Saturating counters for empty-output cycles and dropped responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_empty_q <= '0;
      perf_disc_q  <= '0;
    end else begin
      if ((count_q == '0) && !redirect && (perf_empty_q != 32'hFFFF_FFFF)) begin
        perf_empty_q <= perf_empty_q + 32'd1;
      end
      if (rsp_drop && (perf_disc_q != 32'hFFFF_FFFF)) begin
        perf_disc_q <= perf_disc_q + 32'd1;
      end
    end
  end

  assign perf_empty_cycles = perf_empty_q;
  assign perf_discards     = perf_disc_q;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed tables, corner sequences, then random traffic vs a queue model.
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_gnt, imem_rvalid, redirect, stall, out_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_empty_cycles, perf_discards;
`endif

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc)
`ifdef PREFETCH_PERF_EN
    , .perf_empty_cycles(perf_empty_cycles), .perf_discards(perf_discards)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;

  // memory model: granted requests with the cycle their response is due
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  // reference model: outstanding requests, and the buffered instruction queue
  typedef struct { logic [31:0] pc; bit stale; } oreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  oreq_t oq[$];
  ent_t  fq[$];
  logic [31:0] m_pc = RESET_PC;
  int m_disc = 0;
  int m_empty = 0;

  // values sampled in the most recent step
  bit          s_req, s_vld;
  logic [31:0] s_addr, s_pc, s_instr;

  typedef struct {
    bit stl; bit g;
    bit e_req; logic [31:0] e_addr;
    bit e_vld; logic [31:0] e_pc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit rdr, input logic [31:0] rpc,
                      input bit stl, input bit g);
    bit rv, e_req, e_vld;
    int live, due;
    logic [31:0] rd;
    oreq_t o;
    @(negedge clk);
    reset = rst; redirect = rdr; redirect_pc = rpc; stall = stl; imem_gnt = g;
    rv = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
    rd = rv ? (mq[0].addr ^ 32'hFFFF_FFFF) : $urandom;
    imem_rvalid = rv;
    imem_rdata = rd;
    #1;
    live = 0;
    foreach (oq[i]) if (!oq[i].stale) live++;
    e_req = !rst && !rdr && (fq.size() + live < DEPTH) && (oq.size() < DEPTH);
    e_vld = !rst && !rdr && (fq.size() > 0);
    s_req = imem_req; s_vld = out_valid; s_addr = imem_addr; s_pc = out_pc; s_instr = out_instr;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(e_vld));
    if (e_vld) begin
      chk("out_pc", out_pc, fq[0].pc);
      chk("out_instr", out_instr, fq[0].instr);
    end else if (rst) begin
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
    end
`ifdef PREFETCH_PERF_EN
    if (!rst) begin
      chk("perf_discards", perf_discards, 32'(m_disc));
      chk("perf_empty_cycles", perf_empty_cycles, 32'(m_empty));
    end
`endif
    @(posedge clk);
    if (rst) begin
      fq.delete(); oq.delete(); mq.delete();
      m_pc = RESET_PC; m_disc = 0; m_empty = 0;
    end else begin
      if (fq.size() == 0 && !rdr) m_empty++;
      if (e_vld && !stl) void'(fq.pop_front());
      if (rv) begin
        void'(mq.pop_front());
        o = oq.pop_front();
        if (o.stale || rdr) m_disc++;
        else fq.push_back('{pc: o.pc, instr: rd});
      end
      if (e_req && g) begin
        due = cyc + lat;
        if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
        oq.push_back('{pc: m_pc, stale: 1'b0});
        mq.push_back('{addr: m_pc, due: due});
        m_pc = m_pc + 32'd4;
      end
      if (rdr) begin
        fq.delete();
        foreach (oq[i]) oq[i].stale = 1'b1;
        m_pc = rpc;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1, 0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 0, 0);
  endtask

  task automatic run_table(input vec_t t[$]);
    foreach (t[i]) begin
      step(0, 0, 32'h0, t[i].stl, t[i].g);
      chk("tbl_req", 32'(s_req), 32'(t[i].e_req));
      if (t[i].e_req) chk("tbl_addr", s_addr, t[i].e_addr);
      chk("tbl_vld", 32'(s_vld), 32'(t[i].e_vld));
      if (t[i].e_vld) chk("tbl_pc", s_pc, t[i].e_pc);
    end
  endtask

  initial begin
    vec_t t1[$];
    vec_t t2[$];
    bit found;

    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // 1: streaming, 1-cycle memory
    t1 = '{
      '{0, 1, 1, 32'h3000, 0, 32'h0},
      '{0, 1, 1, 32'h3004, 0, 32'h0},
      '{0, 1, 1, 32'h3008, 1, 32'h3000},
      '{0, 1, 1, 32'h300C, 1, 32'h3004},
      '{0, 1, 1, 32'h3010, 1, 32'h3008}
    };
    // 2: stall fills the queue, then drains in order
    t2 = '{
      '{1, 1, 1, 32'h3000, 0, 32'h0},
      '{1, 1, 1, 32'h3004, 0, 32'h0},
      '{1, 1, 1, 32'h3008, 1, 32'h3000},
      '{1, 1, 1, 32'h300C, 1, 32'h3000},
      '{1, 1, 0, 32'h0,    1, 32'h3000},
      '{1, 1, 0, 32'h0,    1, 32'h3000},
      '{1, 1, 0, 32'h0,    1, 32'h3000},
      '{0, 1, 0, 32'h0,    1, 32'h3000},
      '{0, 1, 1, 32'h3010, 1, 32'h3004},
      '{0, 1, 1, 32'h3014, 1, 32'h3008},
      '{0, 1, 1, 32'h3018, 1, 32'h300C},
      '{0, 1, 1, 32'h301C, 1, 32'h3010}
    };

    lat = 1;
    do_reset();
    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 1);
    chk("t1_first_instr", s_instr, 32'hFFFF_CFFF);
    do_reset();
    run_table(t1);

    do_reset();
    run_table(t2);

    // 3: three requests in flight at redirect, 4-cycle memory
    lat = 4;
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 1);
    step(0, 1, 32'h0000_4000, 0, 1);
    step(0, 0, 32'h0, 0, 1);
    chk("t3_req", 32'(s_req), 32'h1);
    chk("t3_addr", s_addr, 32'h0000_4000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 32'h0, 0, 1);
      if (s_vld) begin
        found = 1'b1;
        chk("t3_first_pc", s_pc, 32'h0000_4000);
      end
    end
    if (!found) chk("t3_first_out_timeout", 32'h0, 32'h1);
`ifdef PREFETCH_PERF_EN
    #1;
    chk("t3_perf_discards", perf_discards, 32'd3);
`endif

    // 4: redirect together with a response and a would-be pop
    lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 1);
    step(0, 1, 32'h0000_5000, 0, 1);
    chk("t4_vld_in_redirect", 32'(s_vld), 32'h0);
    step(0, 0, 32'h0, 0, 1);
    chk("t4_vld_after", 32'(s_vld), 32'h0);
    chk("t4_addr", s_addr, 32'h0000_5000);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 1);

    // 5: request held without grant
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 32'h0, 0, 0);
      chk("t5_req_held", 32'(s_req), 32'h1);
      chk("t5_addr_held", s_addr, 32'h0000_3000);
    end
    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 0);
    chk("t5_addr_next", s_addr, 32'h0000_3004);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 1);

    // 6: reset mid-stream
    lat = 2;
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 1, 1);
    step(1, 0, 32'h0, 1, 1);
    chk("t6_vld", 32'(s_vld), 32'h0);
    chk("t6_req", 32'(s_req), 32'h0);
    step(0, 0, 32'h0, 0, 1);
    chk("t6_restart_addr", s_addr, 32'h0000_3000);

    // random traffic, including concurrent redirect/reset and address wrap
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 31) == 0), rpc,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
